// File: rtl/decode_stage.sv
// decode_stage: single-cycle instruction decode register between fetch and execute.
// Splits an instruction word into ALU op, register indices, a sign-extended
// immediate and class flags, all registered with one cycle of latency.
// Execute stalls freeze the output register. A taken branch flushes the
// decoded instruction.
// Optional feature, controlled by the macro DECODE_HAZARD_EN: load-use hazard
// detection. When enabled, it inserts one bubble and asks fetch to hold
// while a load's destination is still being produced.
module decode_stage #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  input  logic            stall_i,
  input  logic            branch_i,
  output logic            stall_o,
  output logic            v_o,
  output logic [ADDR-1:0] pc_o,
  output logic [3:0]      alu_op_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [WORD-1:0] imm_o,
  output logic            use_imm_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            is_branch_o,
  output logic            reg_we_o
);

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM     = 2'b10;
  localparam logic [1:0] CLS_BRANCH  = 2'b11;

  logic [1:0]      cls;
  logic [WORD-1:0] dec_imm;
  logic            dec_use_imm;
  logic            dec_load;
  logic            dec_store;
  logic            dec_branch;
  logic            dec_we;
  logic            hazard;

  // Sign-extend the 16-bit immediate field to the full data word.
  function automatic logic [WORD-1:0] sext16(input logic [15:0] val);
    return {{(WORD-16){val[15]}}, val};
  endfunction

  assign cls = inst_i[31:30];

  // Decode class flags and immediate from the incoming instruction.
  always_comb begin
    dec_imm     = sext16(inst_i[15:0]);
    dec_use_imm = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_branch  = 1'b0;
    dec_we      = 1'b0;
    case (cls)
      CLS_ALU_REG: begin
        dec_we = 1'b1;
      end
      CLS_ALU_IMM: begin
        dec_use_imm = 1'b1;
        dec_we      = 1'b1;
      end
      CLS_MEM: begin
        dec_use_imm = 1'b1;
        if (inst_i[26]) begin
          dec_store = 1'b1;
        end else begin
          dec_load = 1'b1;
          dec_we   = 1'b1;
        end
      end
      CLS_BRANCH: begin
        dec_branch = 1'b1;
      end
      default: begin
        dec_we = 1'b0;
      end
    endcase
  end

`ifdef DECODE_HAZARD_EN
  logic src_match;

  // Load-use detection: the load held in the output register writes a source of inst_i.
  always_comb begin
    src_match = (inst_i[20:16] == rd_o) ||
                (((cls == CLS_ALU_REG) || (cls == CLS_BRANCH)) && (inst_i[15:11] == rd_o));
    if (v_o && is_load_o && (rd_o != 5'd0) && v_i && src_match) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end
`else
  // No hazard detection in this build; only the execute stall reaches fetch.
  always_comb begin
    hazard = 1'b0;
  end
`endif

  // Stall to fetch: downstream stall, or a load-use bubble unless a branch flushes anyway.
  always_comb begin
    stall_o = stall_i | (hazard & ~branch_i);
  end

  // Output register: hold on stall, drop valid on flush or bubble, otherwise capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_o         <= 1'b0;
      pc_o        <= '0;
      alu_op_o    <= 4'd0;
      rd_o        <= 5'd0;
      rs_o        <= 5'd0;
      rt_o        <= 5'd0;
      imm_o       <= '0;
      use_imm_o   <= 1'b0;
      is_load_o   <= 1'b0;
      is_store_o  <= 1'b0;
      is_branch_o <= 1'b0;
      reg_we_o    <= 1'b0;
    end else if (!stall_i) begin
      if (branch_i || hazard) begin
        v_o <= 1'b0;
      end else begin
        v_o         <= v_i;
        pc_o        <= pc_i;
        alu_op_o    <= inst_i[29:26];
        rd_o        <= inst_i[25:21];
        rs_o        <= inst_i[20:16];
        rt_o        <= inst_i[15:11];
        imm_o       <= dec_imm;
        use_imm_o   <= dec_use_imm;
        is_load_o   <= dec_load;
        is_store_o  <= dec_store;
        is_branch_o <= dec_branch;
        reg_we_o    <= dec_we;
      end
    end
  end

endmodule
